// File: rtl/output_port_reg.sv
// CPU output port: captures the data bus on the OUT strobe and drives the seven-segment display driver.
// Optional OUTPUT_PORT_EDGE_LOAD_EN: capture only on the first cycle of each load_i assertion.
module output_port_reg #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000,
  parameter logic [1:0]  RESET_MODE      = 2'b00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bus_i,
  input  logic       load_i,
  input  logic       mode_btn_i,
  output logic [7:0] value_o,
  output logic       hex_o,
  output logic       neg_o,
  output logic [1:0] mode_o,
  output logic       valid_o,
  output logic       update_o
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    MODE_UNSIGNED = 2'b00,
    MODE_SIGNED   = 2'b01,
    MODE_HEX      = 2'b10
  } mode_e;

  logic             capture;
  logic [7:0]       value_q;
  logic             valid_q;
  logic             update_q;
  logic [1:0]       sync_q;
  logic             db_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press;
  mode_e            mode_q;
  mode_e            mode_next;
  logic             hex_q;
  logic             neg_q;

`ifdef OUTPUT_PORT_EDGE_LOAD_EN
  logic load_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) load_q <= 1'b0;
    else        load_q <= load_i;
  end

  assign capture = load_i & ~load_q;
`else
  assign capture = load_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q  <= '0;
      valid_q  <= 1'b0;
      update_q <= 1'b0;
    end else begin
      update_q <= capture;
      if (capture) begin
        value_q <= bus_i;
        valid_q <= 1'b1;
      end
    end
  end

  // Any mismatch-free cycle restarts the count, so only a level stable for
  // DEBOUNCE_CYCLES consecutive synced cycles is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      db_q   <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], mode_btn_i};
      if (sync_q[1] != db_q) begin
        if (cnt_q == CNT_LAST) begin
          db_q  <= sync_q[1];
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // Rising edge of the debounced level, visible on the edge that updates db
  assign press = sync_q[1] & ~db_q & (cnt_q == CNT_LAST);

  always_comb begin
    mode_next = mode_q;
    case (mode_q)
      MODE_UNSIGNED: if (press) mode_next = MODE_SIGNED;
      MODE_SIGNED:   if (press) mode_next = MODE_HEX;
      MODE_HEX:      if (press) mode_next = MODE_UNSIGNED;
      default:       mode_next = MODE_UNSIGNED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= mode_e'(RESET_MODE);
      hex_q  <= (RESET_MODE == 2'b10);
      neg_q  <= (RESET_MODE == 2'b01);
    end else begin
      mode_q <= mode_next;
      hex_q  <= (mode_next == MODE_HEX);
      neg_q  <= (mode_next == MODE_SIGNED);
    end
  end

  assign value_o  = value_q;
  assign valid_o  = valid_q;
  assign update_o = update_q;
  assign mode_o   = mode_q;
  assign hex_o    = hex_q;
  assign neg_o    = neg_q;

endmodule

// File: tb/tb_output_port_reg.sv
// Scoreboard bench for output_port_reg: stimulus pushes expected captures and mode changes, a monitor pops and compares.
module tb_output_port_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bus_i = '0;
  logic       load_i = 1'b0;
  logic       mode_btn_i = 1'b0;
  logic [7:0] value_o;
  logic       hex_o;
  logic       neg_o;
  logic [1:0] mode_o;
  logic       valid_o;
  logic       update_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_val_q[$];
  logic [1:0] exp_mode_q[$];
  logic [1:0] last_mode = 2'b00;

  output_port_reg #(.DEBOUNCE_CYCLES(4), .RESET_MODE(2'b00)) dut (
    .clk(clk), .rst_n(rst_n), .bus_i(bus_i), .load_i(load_i), .mode_btn_i(mode_btn_i),
    .value_o(value_o), .hex_o(hex_o), .neg_o(neg_o), .mode_o(mode_o),
    .valid_o(valid_o), .update_o(update_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load(input logic [7:0] v);
    bus_i  = v;
    load_i = 1'b1;
    exp_val_q.push_back(v);
    tick();
    load_i = 1'b0;
  endtask

  task automatic button(input int hold, input int gap);
    mode_btn_i = 1'b1;
    tick(hold);
    mode_btn_i = 1'b0;
    tick(gap);
  endtask

  // Monitor: pops an expected value on every update pulse and an expected mode on every mode change
  always @(negedge clk) begin
    if (!rst_n) begin
      last_mode = 2'b00;
    end else begin
      if (update_o) begin
        if (exp_val_q.size() == 0) begin
          check("unexpected_update", 8'h01, 8'h00);
        end else begin
          check("capture_value", value_o, exp_val_q.pop_front());
          check("capture_valid", {7'd0, valid_o}, 8'h01);
        end
      end
      if (mode_o !== last_mode) begin
        if (exp_mode_q.size() == 0) begin
          check("unexpected_mode", {6'd0, mode_o}, {6'd0, last_mode});
        end else begin
          logic [1:0] em;
          em = exp_mode_q.pop_front();
          check("mode", {6'd0, mode_o}, {6'd0, em});
          check("mode_hex", {7'd0, hex_o}, {7'd0, (em == 2'b10)});
          check("mode_neg", {7'd0, neg_o}, {7'd0, (em == 2'b01)});
        end
        last_mode = mode_o;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #23 rst_n = 1'b1;
    tick(20);
    check("rst_value", value_o, 8'h00);
    check("rst_valid", {7'd0, valid_o}, 8'h00);
    check("rst_mode", {6'd0, mode_o}, 8'h00);
    check("rst_hex", {7'd0, hex_o}, 8'h00);
    check("rst_neg", {7'd0, neg_o}, 8'h00);

    load(8'hA5);
    bus_i = 8'h3C;
    tick(3);
    check("hold_value", value_o, 8'hA5);
    check("hold_update", {7'd0, update_o}, 8'h00);

    // Load held high for three cycles with a changing bus
    load_i = 1'b1;
    bus_i  = 8'h01;
    exp_val_q.push_back(8'h01);
    tick();
    bus_i = 8'h02;
`ifndef OUTPUT_PORT_EDGE_LOAD_EN
    exp_val_q.push_back(8'h02);
`endif
    tick();
    bus_i = 8'h03;
`ifndef OUTPUT_PORT_EDGE_LOAD_EN
    exp_val_q.push_back(8'h03);
`endif
    tick();
    load_i = 1'b0;
`ifdef OUTPUT_PORT_EDGE_LOAD_EN
    check("multi_load_value", value_o, 8'h01);
`else
    check("multi_load_value", value_o, 8'h03);
`endif
    tick(3);

    // Short bounces are rejected, a 10-cycle hold advances once
    button(2, 8);
    button(3, 8);
    check("short_pulse_mode", {6'd0, mode_o}, 8'h00);
    exp_mode_q.push_back(2'b01);
    button(10, 10);
    check("first_press_neg", {7'd0, neg_o}, 8'h01);
    exp_mode_q.push_back(2'b10);
    button(10, 10);
    exp_mode_q.push_back(2'b00);
    button(10, 10);
    exp_mode_q.push_back(2'b01);
    button(10, 10);

    // Acceptance lands on the 6th edge after the press is driven; load on that same edge
    mode_btn_i = 1'b1;
    tick(5);
    check("pre_accept_mode", {6'd0, mode_o}, 8'h01);
    exp_mode_q.push_back(2'b10);
    load(8'h80);
    check("same_edge_mode", {6'd0, mode_o}, 8'h02);
    check("same_edge_value", value_o, 8'h80);
    tick(5);
    mode_btn_i = 1'b0;
    tick(10);

    // Asynchronous reset mid-debounce
    load(8'h55);
    mode_btn_i = 1'b1;
    tick(3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_value", value_o, 8'h00);
    check("async_rst_valid", {7'd0, valid_o}, 8'h00);
    check("async_rst_mode", {6'd0, mode_o}, 8'h00);
    check("async_rst_hex", {7'd0, hex_o}, 8'h00);
    check("async_rst_update", {7'd0, update_o}, 8'h00);
    #10 rst_n = 1'b1;
    tick(5);
    check("post_rst_pre_accept", {6'd0, mode_o}, 8'h00);
    exp_mode_q.push_back(2'b01);
    tick();
    check("post_rst_accept", {6'd0, mode_o}, 8'h01);
    tick(5);
    mode_btn_i = 1'b0;
    tick(10);

    check("values_left", 8'(exp_val_q.size()), 8'h00);
    check("modes_left", 8'(exp_mode_q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
